// File: rtl/mau_pkg.sv
// Shared encodings and helpers for the memory access unit.
// Size codes, FSM state type and the alignment rule live here so the top and lane logic agree.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_READ   = 2'b01,
    ST_WRITE  = 2'b10,
    ST_FINISH = 2'b11
  } state_t;

  // Illegal size code counts as misaligned so the top has a single error test.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_lane_logic.sv
// Little-endian lane extraction with sign/zero extension, and sub-word merge for RMW stores.
// Purely combinational; the top registers whichever result it needs.
module mau_lane_logic
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word[{offset, 3'b000} +: 8];
  assign half_lane = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    load_val   = word;
    store_word = word;
    case (size)
      SZ_BYTE: begin
        load_val = {{24{sign_ext & byte_lane[7]}}, byte_lane};
        store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_val = {{16{sign_ext & half_lane[15]}}, half_lane};
        store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator turning load/store requests into word-wide RAM transactions,
// including read-modify-write for byte/halfword stores and alignment error reporting.
//
//   state     | meaning
//   ST_IDLE   | waiting for req
//   ST_READ   | address on the RAM, counting down READ_LATENCY before capture
//   ST_WRITE  | mem_write high for exactly this cycle
//   ST_FINISH | done pulse; a new req is accepted here as in IDLE
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

  state_t      state, state_next;
  logic [1:0]  cnt;
  logic        we_q, sign_ext_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q;
  logic        accept, illegal, word_store;
  logic [31:0] load_val, store_word;

  assign accept     = req && (state == ST_IDLE || state == ST_FINISH);
  assign illegal    = is_misaligned(size, addr[1:0]);
  assign word_store = we && (size == SZ_WORD);

  // Lane logic works straight off mem_rdata so the result registers on the capture edge.
  mau_lane_logic u_lane (
    .word       (mem_rdata),
    .offset     (off_q),
    .size       (size_q),
    .sign_ext   (sign_ext_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_FINISH: begin
        state_next = ST_IDLE;
        if (req) begin
          if (illegal)         state_next = ST_FINISH;
          else if (word_store) state_next = ST_WRITE;
          else                 state_next = ST_READ;
        end
      end
      ST_READ:  if (cnt == 2'd0) state_next = we_q ? ST_WRITE : ST_FINISH;
      ST_WRITE: state_next = ST_FINISH;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 2'd0;
      we_q        <= 1'b0;
      sign_ext_q  <= 1'b0;
      size_q      <= SZ_BYTE;
      off_q       <= 2'b00;
      wdata_q     <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= 32'd0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= 32'd0;
    end else begin
      state     <= state_next;
      busy      <= (state_next == ST_READ) || (state_next == ST_WRITE);
      done      <= (state_next == ST_FINISH);
      mem_write <= (state_next == ST_WRITE);
      err       <= accept && illegal;
      if (accept) begin
        we_q        <= we;
        size_q      <= size;
        sign_ext_q  <= sign_ext;
        off_q       <= addr[1:0];
        wdata_q     <= wdata;
        cnt         <= CNT_LOAD;
        mem_address <= {addr[ADDR_W-1:2], 2'b00};
        if (word_store && !illegal) mem_wdata <= wdata;
      end
      if (state == ST_READ) begin
        if (cnt != 2'd0) cnt       <= cnt - 2'd1;
        else if (we_q)   mem_wdata <= store_word;
        else             rdata     <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: behavioural RAM, transaction-level reference model, per-cycle compare,
// directed literal checks and a randomized request stream.
module tb_mem_access_unit;

  localparam int L = 1;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        busy, done, err, mem_write;
  logic [31:0] rdata, mem_address, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mem_access_unit #(.READ_LATENCY(L), .ADDR_W(32)) dut (
    .clock(clock), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return ({24'd0, i} * 32'h9E3779B9) ^ 32'h5A5A00C3;
  endfunction

  // Behavioural RAM: self-preloads, then combinational read (latency 1) and clocked write.
  logic [31:0] ram [0:255];
  logic [7:0]  pre_idx = 8'd0;
  logic        ram_ready = 1'b0;
  assign mem_rdata = ram[mem_address[9:2]];
  always @(posedge clock) begin
    if (!ram_ready) begin
      ram[pre_idx] <= init_word(pre_idx);
      pre_idx      <= pre_idx + 8'd1;
      if (pre_idx == 8'd255) ram_ready <= 1'b1;
    end else if (mem_write) begin
      ram[mem_address[9:2]] <= mem_wdata;
    end
  end

  // Reference model: one transaction record plus architectural rdata/address history.
  logic [31:0] model_ram [0:255];
  bit          t_valid = 0, t_load_ok = 0, t_err = 0;
  int          t_acc = 0, t_done_e = 0, t_wr_e = -1, last_n0 = 0;
  logic [31:0] t_rnew = 0, t_wword = 0, t_addr = 0, r_old = 0, a_old = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_req(input bit w, input logic [1:0] sz, input bit sx,
                           input logic [31:0] a, input logic [31:0] wd, input int n0);
    logic [31:0] word, lane, merged;
    int sh, d;
    bit bad_a;
    if (t_valid && n0 <= t_done_e) return;
    if (t_valid) begin
      if (t_load_ok) r_old = t_rnew;
      a_old = t_addr;
    end
    bad_a  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    word   = model_ram[a[9:2]];
    lane   = word;
    merged = wd;
    if (sz == 2'd0) begin
      sh     = 8 * a[1:0];
      lane   = (word >> sh) & 32'hFF;
      if (sx && lane[7]) lane = lane | 32'hFFFFFF00;
      merged = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'd1) begin
      sh     = a[1] ? 16 : 0;
      lane   = (word >> sh) & 32'hFFFF;
      if (sx && lane[15]) lane = lane | 32'hFFFF0000;
      merged = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    if (bad_a)              d = 1;
    else if (w && sz == 2)  d = 2;
    else if (!w)            d = L + 1;
    else                    d = L + 2;
    t_valid   = 1;
    t_acc     = n0;
    t_done_e  = n0 + d - 1;
    t_wr_e    = (w && !bad_a) ? n0 + d - 2 : -1;
    t_load_ok = !w && !bad_a;
    t_err     = bad_a;
    t_rnew    = lane;
    t_wword   = merged;
    t_addr    = {a[31:2], 2'b00};
    last_n0   = n0;
  endtask

  task automatic model_reset();
    t_valid = 0;
    t_wr_e  = -1;
    r_old   = 32'd0;
    a_old   = 32'd0;
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin : compare
    int e;
    bit x_busy, x_done, x_mw;
    logic [31:0] x_rd, x_addr;
    for (int i = 0; i < 256; i++) model_ram[i] = init_word(8'(i));
    forever begin
      @(negedge clock);
      if (rst_n) begin
        e      = cyc;
        x_busy = t_valid && e >= t_acc && e < t_done_e;
        x_done = t_valid && e == t_done_e;
        x_mw   = t_valid && e == t_wr_e;
        x_rd   = (t_valid && t_load_ok && e >= t_done_e) ? t_rnew : r_old;
        x_addr = (t_valid && e >= t_acc) ? t_addr : a_old;
        chk("busy", {31'd0, busy}, {31'd0, x_busy});
        chk("done", {31'd0, done}, {31'd0, x_done});
        chk("err", {31'd0, err}, {31'd0, x_done && t_err});
        chk("mem_write", {31'd0, mem_write}, {31'd0, x_mw});
        chk("rdata", rdata, x_rd);
        chk("mem_address", mem_address, x_addr);
        if (x_mw) begin
          chk("mem_wdata", mem_wdata, t_wword);
          model_ram[t_addr[9:2]] = t_wword;
        end
      end
    end
  end

  task automatic pulse(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    model_req(w, sz, sx, a, wd, cyc + 1);
    @(negedge clock); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit e_out);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    lat   = -1;
    e_out = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_done: got no done within 20 cycles want done");
    end else begin
      lat   = cyc - last_n0 + 1;
      e_out = err;
    end
  endtask

  task automatic op(input bit w, input logic [1:0] sz, input bit sx,
                    input logic [31:0] a, input logic [31:0] wd,
                    output int lat, output bit e_out);
    pulse(w, sz, sx, a, wd);
    wait_done(lat, e_out);
    @(negedge clock); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) @(negedge clock);
    #1 rst_n = 1'b1;
  endtask

  initial begin : driver
    int lat;
    bit ev;
    logic [1:0] rsz;
    int r;

    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    do_reset(262);
    @(negedge clock); #1;

    op(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, lat, ev);
    chk("lat_word_store", 32'(lat), 32'd2);
    op(0, 2'd2, 0, 32'h10, 32'h0, lat, ev);
    chk("lat_word_load", 32'(lat), 32'd2);
    chk("err_word_load", {31'd0, ev}, 32'd0);
    chk("rdata_word_load", rdata, 32'hDEADBEEF);

    op(1, 2'd2, 0, 32'h20, 32'h11223344, lat, ev);
    op(1, 2'd0, 0, 32'h23, 32'h000000AB, lat, ev);
    chk("lat_byte_rmw", 32'(lat), 32'd3);
    op(0, 2'd2, 0, 32'h20, 32'h0, lat, ev);
    chk("rdata_after_rmw", rdata, 32'hAB223344);

    op(1, 2'd2, 0, 32'h30, 32'h80017F80, lat, ev);
    op(0, 2'd0, 1, 32'h30, 32'h0, lat, ev);
    chk("byte_signed", rdata, 32'hFFFFFF80);
    op(0, 2'd0, 0, 32'h30, 32'h0, lat, ev);
    chk("byte_unsigned", rdata, 32'h00000080);
    op(0, 2'd1, 1, 32'h32, 32'h0, lat, ev);
    chk("half_signed", rdata, 32'hFFFF8001);
    op(0, 2'd1, 0, 32'h30, 32'h0, lat, ev);
    chk("half_unsigned", rdata, 32'h00007F80);

    op(0, 2'd1, 0, 32'h05, 32'h0, lat, ev);
    chk("lat_err_half", 32'(lat), 32'd1);
    chk("err_half", {31'd0, ev}, 32'd1);
    op(1, 2'd2, 0, 32'h06, 32'h12345678, lat, ev);
    chk("err_word", {31'd0, ev}, 32'd1);
    chk("lat_err_word", 32'(lat), 32'd1);
    op(0, 2'd3, 0, 32'h00, 32'h0, lat, ev);
    chk("err_size11", {31'd0, ev}, 32'd1);
    chk("rdata_kept_after_err", rdata, 32'h00007F80);

    // Back-to-back: ignored req while busy, then a req on the done cycle.
    pulse(0, 2'd2, 0, 32'h10, 32'h0);
    pulse(1, 2'd2, 0, 32'h10, 32'h0);
    chk("b2b_done_cycle", {31'd0, done}, 32'd1);
    chk("b2b_busy_low_on_done", {31'd0, busy}, 32'd0);
    chk("b2b_first_load", rdata, 32'hDEADBEEF);
    pulse(0, 2'd2, 0, 32'h30, 32'h0);
    wait_done(lat, ev);
    chk("b2b_second_load", rdata, 32'h80017F80);
    @(negedge clock); #1;
    op(0, 2'd2, 0, 32'h10, 32'h0, lat, ev);
    chk("ignored_store_no_effect", rdata, 32'hDEADBEEF);

    // Asynchronous reset mid-transaction clears every output at once.
    pulse(0, 2'd2, 0, 32'h30, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_err", {31'd0, err}, 32'd0);
    chk("async_mem_write", {31'd0, mem_write}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    chk("async_mem_address", mem_address, 32'd0);
    chk("async_mem_wdata", mem_wdata, 32'd0);
    do_reset(2);
    @(negedge clock); #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_mem_write", {31'd0, mem_write}, 32'd0);

    // Abort a byte RMW while it is still reading; the RAM must not change.
    pulse(1, 2'd0, 0, 32'h20, 32'h000000CD);
    do_reset(2);
    @(negedge clock); #1;
    op(0, 2'd2, 0, 32'h20, 32'h0, lat, ev);
    chk("abort_ram_unchanged", rdata, 32'hAB223344);

    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      rsz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      pulse(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      #1;
    end
    repeat (10) @(negedge clock);
    #1;
    for (int i = 0; i < 256; i++) chk("ram_final", ram[i], model_ram[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side initiator for the word-wide data RAM port: write strobe, word address, write data, read data.
- Turns single-cycle load/store requests from the execute/memory stage into word-granular RAM transactions.
- Handles byte/halfword sizes, sign/zero extension and read-modify-write for sub-word stores.
- Reports alignment errors without touching memory.

Parameters:
READ_LATENCY, 1, cycles from mem_address valid to mem_rdata valid (1..3)
ADDR_W, 32, byte-address width

Ports:
clock  in  1  system clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  single-cycle request strobe; accepted only when busy=0
we  in  1  1=store, 0=load
size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend
addr  in  ADDR_W  byte address
wdata  in  32  store data, right-aligned for sub-word stores
busy  out  1  transaction in flight
done  out  1  one-cycle completion pulse
err  out  1  valid with done: misaligned address or illegal size
rdata  out  32  load result, valid with done, held until next done
mem_write  out  1  RAM write strobe
mem_address  out  ADDR_W  word-aligned byte address ([1:0]=00)
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data

Behaviour:
- Reset (async, immediate): state IDLE; busy, done, err, mem_write=0; rdata, mem_address, mem_wdata=0.
- All outputs are registered.
- States: IDLE, READ, WRITE, FINISH.
- Accept (IDLE, req=1, rising edge E0):
  - Latch we, size, sign_ext, addr[1:0], wdata.
  - mem_address <= {addr[ADDR_W-1:2],2'b00}; busy <= 1.
- Illegal: size=11, halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Go to FINISH with err=1; no memory access.
- Word store: go to WRITE with mem_write=1 and mem_wdata=wdata for exactly one cycle.
- Load or sub-word store: go to READ. A counter waits READ_LATENCY edges, then captures mem_rdata into an internal word register.
  - Load: extract the lane and go to FINISH.
  - Sub-word store: merge and go to WRITE.
- Lanes are little-endian.
  - Byte k = bits [8k+7:8k], k=addr[1:0].
  - Halfword = bits [15:0] if addr[1]=0, else [31:16].
- Extension:
  - Byte: sign-extend bit 7 if sign_ext, else zero-fill.
  - Halfword: sign-extend bit 15 if sign_ext, else zero-fill.
  - Word: passed through unchanged; sign_ext ignored.
- Merge: replace only the addressed lane with wdata[7:0] or wdata[15:0]; other bytes keep the read value.
- WRITE lasts one cycle; mem_write deasserts on the following edge; next state FINISH.
- FINISH lasts one cycle: done=1, err as determined, busy=0 on the following edge, return to IDLE.
- Latency from E0 to done high (L=READ_LATENCY):
  - Error: 1 cycle.
  - Word store: 2 cycles.
  - Load: L+1 cycles.
  - Sub-word store: L+2 cycles.
- The next req may be accepted on the edge where done is high; busy is low in that cycle.
- req while busy=1 is ignored: no queueing and no error.
- mem_write is high only in WRITE. Reset during READ or WRITE abandons the transaction; a partial RMW never writes.
- rdata is updated only on a successful load; stores and errors leave it unchanged.

Decomposition:
- Package mau_pkg holds:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State encoding.
  - Function is_misaligned(size, off).
- One combinational sub-module, mau_lane_logic:
  - Inputs: word, offset, size, sign_ext, wdata.
  - Outputs: extracted load value and merged store word.
- FSM, counter and registers live in mem_access_unit.

Test Plan (READ_LATENCY=1, behavioural RAM model):
1. Reset: hold rst_n=0 mid-run -> all outputs 0 immediately; after release, busy=0 and no mem_write.
2. Word store then load:
   - Store 0xDEADBEEF @0x10 -> mem_write high one cycle at E0+1 with mem_address=0x10; done at E0+2.
   - Word load @0x10 -> rdata=0xDEADBEEF, done at E0+2, err=0.
3. Byte store RMW: RAM[0x20]=0x11223344, byte store wdata=0x000000AB @0x23 -> single write of 0xAB223344; done at E0+3.
4. Extension: RAM[0x30]=0x8001_7F80.
   - Byte @0x30 signed -> 0xFFFFFF80; unsigned -> 0x00000080.
   - Half @0x32 signed -> 0xFFFF8001; half @0x30 unsigned -> 0x00007F80.
5. Errors:
   - Half @0x05 -> done+err at E0+1, mem_write never asserted, rdata unchanged.
   - Word @0x06 and size=11 behave the same way.
6. Abort and back-to-back:
   - Drop rst_n during READ of byte store to 0x20 -> RAM unchanged.
   - req pulsed while busy -> ignored.
   - req on the done cycle -> accepted.
